// File: rtl/cache_pkg.sv
// cache_pkg: shared types, default geometry and helpers for the cache and its refill controller
package cache_pkg;

    typedef enum logic [2:0] {IDLE, WB, FILL, RESP, CLR} state_t;

    localparam int CACHE_LINE_SIZE_BYTES = 64;
    localparam int CACHE_ADDRESS_WIDTH   = 32;
    localparam int CACHE_BUS_WIDTH       = 32;
    localparam int CACHE_OFFSET_BITS     = 6;

    function automatic int line_bits(input int line_bytes);
        return line_bytes * 8;
    endfunction

    function automatic int beats(input int line_bytes, input int bus_width);
        return (line_bytes * 8) / bus_width;
    endfunction

    function automatic int beat_bytes(input int bus_width);
        return bus_width / 8;
    endfunction

    localparam int CACHE_LINE_SIZE_BITS = line_bits(CACHE_LINE_SIZE_BYTES);
    localparam int CACHE_BEATS          = beats(CACHE_LINE_SIZE_BYTES, CACHE_BUS_WIDTH);
    localparam int CACHE_BEAT_BYTES     = beat_bytes(CACHE_BUS_WIDTH);

    function automatic logic [CACHE_ADDRESS_WIDTH-1:0] line_align(input logic [CACHE_ADDRESS_WIDTH-1:0] addr);
        return {addr[CACHE_ADDRESS_WIDTH-1:CACHE_OFFSET_BITS], {CACHE_OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/line_beat_shifter.sv
// line_beat_shifter: picks one bus beat out of a victim line and deposits one read beat into a line
//   victim/rd_sel -> wbeat      : write-beat selection
//   line_in/wr_sel/rdata -> line_out : line with beat wr_sel replaced by rdata
module line_beat_shifter #(
    parameter int BUS_WIDTH = 32,
    parameter int BEATS     = 16,
    localparam int IW       = BEATS > 1 ? $clog2(BEATS) : 1,
    localparam int LW       = BUS_WIDTH * BEATS
) (
    input  logic [LW-1:0]        victim,
    input  logic [IW-1:0]        rd_sel,
    output logic [BUS_WIDTH-1:0] wbeat,
    input  logic [LW-1:0]        line_in,
    input  logic [IW-1:0]        wr_sel,
    input  logic [BUS_WIDTH-1:0] rdata,
    output logic [LW-1:0]        line_out
);
    always_comb begin
        wbeat = victim[rd_sel*BUS_WIDTH +: BUS_WIDTH];
        line_out = line_in;
        line_out[wr_sel*BUS_WIDTH +: BUS_WIDTH] = rdata;
    end
endmodule

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: services cache misses over the memory bus (dirty write-back, then line fill)
//   i_miss/i_miss_addr, i_evict/i_evict_addr/i_evict_line : miss request from the cache
//   o_memory_line/o_memory_response                      : refilled line + one-cycle valid pulse
//   o_mem_req/o_mem_we/o_mem_addr/o_mem_wdata            : registered bus beat, held until acked
//   i_mem_ack/i_mem_rdata                                : beat accept / read data
module cache_refill_ctrl import cache_pkg::*; #(
    parameter int LINE_SIZE_BYTES = 64,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int BUS_WIDTH       = 32,
    parameter int OFFSET_BITS     = 6,
    localparam int LINE_SIZE_BITS = line_bits(LINE_SIZE_BYTES),
    localparam int BEATS          = beats(LINE_SIZE_BYTES, BUS_WIDTH),
    localparam int BEAT_BYTES     = beat_bytes(BUS_WIDTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_miss,
    input  logic [ADDRESS_WIDTH-1:0]  i_miss_addr,
    input  logic                      i_evict,
    input  logic [ADDRESS_WIDTH-1:0]  i_evict_addr,
    input  logic [LINE_SIZE_BITS-1:0] i_evict_line,
    output logic [LINE_SIZE_BITS-1:0] o_memory_line,
    output logic                      o_memory_response,
    output logic                      o_mem_req,
    output logic                      o_mem_we,
    output logic [ADDRESS_WIDTH-1:0]  o_mem_addr,
    output logic [BUS_WIDTH-1:0]      o_mem_wdata,
    input  logic                      i_mem_ack,
    input  logic [BUS_WIDTH-1:0]      i_mem_rdata
);
    localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;

    state_t                    state;
    logic [CW-1:0]             beat;
    logic [ADDRESS_WIDTH-1:0]  miss_base, evict_base;
    logic [LINE_SIZE_BITS-1:0] victim;
    logic [BUS_WIDTH-1:0]      next_wdata;
    logic [LINE_SIZE_BITS-1:0] line_dep;

    wire [CW-1:0]            next_beat = beat + 1'b1;
    wire                     last      = beat == CW'(BEATS - 1);
    wire                     ack       = o_mem_req & i_mem_ack;
    wire [ADDRESS_WIDTH-1:0] next_off  = ADDRESS_WIDTH'(next_beat) * ADDRESS_WIDTH'(BEAT_BYTES);
    wire [ADDRESS_WIDTH-1:0] miss_al   = {i_miss_addr[ADDRESS_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    wire [ADDRESS_WIDTH-1:0] evict_al  = {i_evict_addr[ADDRESS_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

    // Write data is prefetched for the beat after the current one so it is ready to register on ack.
    line_beat_shifter #(.BUS_WIDTH(BUS_WIDTH), .BEATS(BEATS)) u_shift (
        .victim   (victim),
        .rd_sel   (next_beat),
        .wbeat    (next_wdata),
        .line_in  (o_memory_line),
        .wr_sel   (beat),
        .rdata    (i_mem_rdata),
        .line_out (line_dep)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            beat              <= '0;
            miss_base         <= '0;
            evict_base        <= '0;
            victim            <= '0;
            o_memory_line     <= '0;
            o_memory_response <= 1'b0;
            o_mem_req         <= 1'b0;
            o_mem_we          <= 1'b0;
            o_mem_addr        <= '0;
            o_mem_wdata       <= '0;
        end else begin
            case (state)
                IDLE: if (i_miss) begin
                    miss_base <= miss_al;
                    beat      <= '0;
                    o_mem_req <= 1'b1;
                    o_mem_we  <= i_evict;
                    if (i_evict) begin
                        evict_base  <= evict_al;
                        victim      <= i_evict_line;
                        o_mem_addr  <= evict_al;
                        o_mem_wdata <= i_evict_line[BUS_WIDTH-1:0];
                        state       <= WB;
                    end else begin
                        o_mem_addr <= miss_al;
                        state      <= FILL;
                    end
                end
                WB: if (ack) begin
                    if (last) begin
                        // Request stays high: the first fill beat follows immediately.
                        beat       <= '0;
                        o_mem_we   <= 1'b0;
                        o_mem_addr <= miss_base;
                        state      <= FILL;
                    end else begin
                        beat        <= next_beat;
                        o_mem_addr  <= evict_base + next_off;
                        o_mem_wdata <= next_wdata;
                    end
                end
                FILL: if (ack) begin
                    o_memory_line <= line_dep;
                    if (last) begin
                        beat      <= '0;
                        o_mem_req <= 1'b0;
                        state     <= RESP;
                    end else begin
                        beat       <= next_beat;
                        o_mem_addr <= miss_base + next_off;
                    end
                end
                RESP: begin
                    o_memory_response <= 1'b1;
                    state             <= CLR;
                end
                CLR: begin
                    // Hold off until the cache drops its miss so the stale level is not re-serviced.
                    o_memory_response <= 1'b0;
                    if (!i_miss) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_refill_ctrl.sv
module tb_cache_refill_ctrl;
    logic         clk = 0;
    logic         rst = 1;
    logic         i_miss = 0;
    logic [31:0]  i_miss_addr = 0;
    logic         i_evict = 0;
    logic [31:0]  i_evict_addr = 0;
    logic [511:0] i_evict_line = 0;
    logic [511:0] o_memory_line;
    logic         o_memory_response;
    logic         o_mem_req;
    logic         o_mem_we;
    logic [31:0]  o_mem_addr;
    logic [31:0]  o_mem_wdata;
    logic         i_mem_ack = 0;
    logic [31:0]  i_mem_rdata = 0;

    cache_refill_ctrl dut (
        .clk(clk), .rst(rst),
        .i_miss(i_miss), .i_miss_addr(i_miss_addr),
        .i_evict(i_evict), .i_evict_addr(i_evict_addr), .i_evict_line(i_evict_line),
        .o_memory_line(o_memory_line), .o_memory_response(o_memory_response),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
        .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } beat_t;
    typedef struct {
        logic [31:0] ma; logic ev; logic [31:0] ea; logic [31:0] vtag;
        int per; logic [31:0] seed; int hold; logic spur; int lat;
        logic [31:0] first; logic [31:0] last;
    } vec_t;

    int checks = 0, fails = 0, cyc = 0;
    int ack_period = 1, wait_cnt = 0, resp_cnt = 0, resp_cyc = 0;
    logic force_ack = 0;
    logic [31:0] rd_seed = 0;
    beat_t beats[$];
    logic pend = 0;
    beat_t held;

    task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory: acks every ack_period-th cycle of a pending request; read data is seed + word index.
    initial forever begin
        @(posedge clk);
        #1;
        if (o_mem_req) begin
            wait_cnt++;
            i_mem_ack = wait_cnt >= ack_period;
            if (i_mem_ack) wait_cnt = 0;
        end else begin
            wait_cnt = 0;
            i_mem_ack = force_ack;
        end
        i_mem_rdata = (o_mem_req && i_mem_ack && !o_mem_we) ? rd_seed + 32'(o_mem_addr[5:2]) : $urandom;
    end

    // Bus monitor: logs completed beats, checks stall stability, records responses.
    always @(negedge clk) begin
        if (rst) pend = 0;
        else begin
            if (pend) check("stall_stable", {o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata}, {1'b1, held});
            if (o_mem_req && i_mem_ack) beats.push_back('{o_mem_we, o_mem_addr, o_mem_we ? o_mem_wdata : i_mem_rdata});
            pend = o_mem_req && !i_mem_ack;
            held = '{o_mem_we, o_mem_addr, o_mem_wdata};
            if (o_memory_response) begin
                resp_cnt++;
                resp_cyc = cyc;
            end
        end
    end

    task automatic scramble;
        i_miss_addr  = $urandom;
        i_evict      = 1'($urandom);
        i_evict_addr = $urandom;
        for (int k = 0; k < 16; k++) i_evict_line[32*k +: 32] = $urandom;
    endtask

    task automatic run_txn(input logic [31:0] ma, input logic ev, input logic [31:0] ea, input logic [511:0] vl,
                           input int per, input logic [31:0] seed, input int hold, input logic spur, input int lat);
        beat_t exp_q[$];
        logic [511:0] exp_line;
        logic [31:0] mb, eb;
        int start, t, n;
        mb = ma & ~32'h3F;
        eb = ea & ~32'h3F;
        if (ev) for (int k = 0; k < 16; k++) exp_q.push_back('{1'b1, eb + 32'(4*k), vl[32*k +: 32]});
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back('{1'b0, mb + 32'(4*k), seed + 32'(k)});
            exp_line[32*k +: 32] = seed + 32'(k);
        end
        beats.delete();
        resp_cnt = 0;
        ack_period = per;
        rd_seed = seed;
        @(posedge clk); #1;
        i_miss = 1; i_miss_addr = ma; i_evict = ev; i_evict_addr = ea; i_evict_line = vl;
        start = cyc;
        t = 0;
        do begin
            @(posedge clk); #1;
            scramble();
            t++;
        end while (resp_cnt == 0 && t < 400);
        if (t >= 400) check("resp_timeout", 1, 0);
        for (int h = 0; h < hold; h++) begin
            force_ack = spur;
            check("clr_no_req", o_mem_req, 0);
            @(posedge clk); #1;
        end
        i_miss = 0;
        force_ack = 0;
        repeat (3) @(posedge clk);
        #1;
        check("resp_count", resp_cnt, 1);
        if (lat != 0) check("latency", resp_cyc - start, lat);
        n = beats.size();
        check("beat_count", n, exp_q.size());
        for (int k = 0; k < n && k < exp_q.size(); k++)
            check($sformatf("beat%0d", k),
                  {beats[k].we, beats[k].addr, beats[k].we ? beats[k].data : 32'h0},
                  {exp_q[k].we, exp_q[k].addr, exp_q[k].we ? exp_q[k].data : 32'h0});
        check("line", o_memory_line, exp_line);
    endtask

    function automatic logic [511:0] tag_line(input logic [31:0] tag);
        logic [511:0] l;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = tag + 32'(k);
        return l;
    endfunction

    initial begin
        vec_t vecs[5];
        logic [511:0] vl;
        logic [31:0] ma, ea, seed;
        logic ev;
        int per, t;
        vecs[0] = '{32'h0000_1234, 0, 32'h0,         32'h0,         1, 32'hA000_0000, 3, 0, 18, 32'h0000_1200, 32'h0000_123C};
        vecs[1] = '{32'h0000_9900, 1, 32'h0000_5640, 32'hD000_0000, 1, 32'hB000_0000, 1, 0, 34, 32'h0000_5640, 32'h0000_993C};
        vecs[2] = '{32'h0000_1234, 0, 32'h0,         32'h0,         3, 32'hC000_0000, 1, 0, 0,  32'h0000_1200, 32'h0000_123C};
        vecs[3] = '{32'hFFFF_FFC8, 0, 32'h0,         32'h0,         1, 32'hE000_0000, 1, 0, 18, 32'hFFFF_FFC0, 32'hFFFF_FFFC};
        vecs[4] = '{32'h0000_0044, 1, 32'h0000_007F, 32'h1234_0000, 2, 32'h5500_0000, 2, 1, 0,  32'h0000_0040, 32'h0000_007C};

        #12;
        check("rst_req", o_mem_req, 0);
        check("rst_we", o_mem_we, 0);
        check("rst_addr", o_mem_addr, 0);
        check("rst_wdata", o_mem_wdata, 0);
        check("rst_resp", o_memory_response, 0);
        check("rst_line", o_memory_line, 0);
        @(posedge clk); #1;
        rst = 0;

        foreach (vecs[i]) begin
            run_txn(vecs[i].ma, vecs[i].ev, vecs[i].ea, tag_line(vecs[i].vtag), vecs[i].per,
                    vecs[i].seed, vecs[i].hold, vecs[i].spur, vecs[i].lat);
            if (beats.size() > 0) begin
                check($sformatf("vec%0d_first", i), beats[0].addr, vecs[i].first);
                check($sformatf("vec%0d_last", i), beats[beats.size()-1].addr, vecs[i].last);
            end else check($sformatf("vec%0d_nobeats", i), 0, 1);
        end

        // Spurious acks in IDLE must not start a transfer or touch the line.
        force_ack = 1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #2;
            check("idle_spur_req", o_mem_req, 0);
        end
        force_ack = 0;
        check("idle_spur_line", o_memory_line, tag_line(32'h5500_0000));

        // Reset in the middle of a fill, after beat 7 has been acked.
        beats.delete();
        ack_period = 1;
        rd_seed = 32'h7700_0000;
        @(posedge clk); #1;
        i_miss = 1; i_miss_addr = 32'h0000_3010; i_evict = 0;
        t = 0;
        while (beats.size() < 8 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("pre_rst_beats", beats.size(), 8);
        @(posedge clk); #3;
        rst = 1;
        #1;
        check("midrst_req", o_mem_req, 0);
        check("midrst_resp", o_memory_response, 0);
        check("midrst_line", o_memory_line, 0);
        i_miss = 0;
        @(posedge clk); #1;
        rst = 0;
        run_txn(32'h0000_3010, 0, 0, 0, 1, 32'h8800_0000, 1, 0, 18);
        if (beats.size() > 0) check("restart_first", beats[0].addr, 32'h0000_3000);

        // Randomised misses against the behavioural model.
        for (int r = 0; r < 12; r++) begin
            ma = $urandom; ea = $urandom; seed = $urandom; ev = 1'($urandom);
            per = $urandom_range(1, 3);
            for (int k = 0; k < 16; k++) vl[32*k +: 32] = $urandom;
            run_txn(ma, ev, ea, vl, per, seed, $urandom_range(1, 3), 1'($urandom),
                    per == 1 ? (ev ? 34 : 18) : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Miss-service stage between the 4-way set-associative cache and the external memory bus.
- On a cache miss it writes back any dirty victim line, then fetches the missing line in bus-width beats and assembles it.
- It returns the full line to the cache with a one-cycle response pulse.
- It owns all memory-bus traffic for the cache; the cache never talks to memory directly.

Parameters:
- LINE_SIZE_BYTES, 64, bytes per cache line
- ADDRESS_WIDTH, 32, byte-address width
- BUS_WIDTH, 32, memory data-bus width in bits; must divide LINE_SIZE_BYTES*8
- OFFSET_BITS, 6, log2(LINE_SIZE_BYTES)
- Derived, not overridable:
  - LINE_SIZE_BITS = LINE_SIZE_BYTES*8
  - BEATS = LINE_SIZE_BITS/BUS_WIDTH
  - BEAT_BYTES = BUS_WIDTH/8

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  asynchronous, active-high reset
- i_miss  input  1  level miss request from the cache
- i_miss_addr  input  ADDRESS_WIDTH  address of the missing access
- i_evict  input  1  victim line is dirty and must be written back
- i_evict_addr  input  ADDRESS_WIDTH  victim line address
- i_evict_line  input  LINE_SIZE_BITS  victim line data
- o_memory_line  output  LINE_SIZE_BITS  assembled refill line, to the cache
- o_memory_response  output  1  one-cycle pulse: o_memory_line valid
- o_mem_req  output  1  memory bus request
- o_mem_we  output  1  1 = write beat, 0 = read beat
- o_mem_addr  output  ADDRESS_WIDTH  beat byte address
- o_mem_wdata  output  BUS_WIDTH  write-beat data
- i_mem_ack  input  1  beat accepted / read data valid
- i_mem_rdata  input  BUS_WIDTH  read-beat data, valid when i_mem_ack is high

Behaviour:
- Reset (async, immediate): all outputs 0, state IDLE, beat counter 0, capture registers 0. Reset mid-burst abandons the burst; o_mem_req drops without waiting for ack.
- States: IDLE, WB, FILL, RESP, CLR.
- IDLE:
  - If i_miss=1, capture i_miss_addr with OFFSET_BITS zeroed (line-aligned) and clear the beat counter.
  - If i_evict=1 in the same cycle, also capture i_evict_addr (aligned) and i_evict_line, then go to WB.
  - Otherwise go to FILL.
  - First o_mem_req is asserted the cycle after capture.
- Bus handshake:
  - o_mem_req, o_mem_we, o_mem_addr and o_mem_wdata are registered and held stable until the cycle i_mem_ack=1.
  - Each ack completes exactly one beat; the counter increments on ack.
  - o_mem_req may stay high back-to-back across beats. It drops the cycle after the final ack.
  - i_mem_ack while o_mem_req=0 is ignored.
- WB:
  - o_mem_we=1, o_mem_addr = evict_base + k*BEAT_BYTES.
  - o_mem_wdata = victim[k*BUS_WIDTH +: BUS_WIDTH] for k = 0..BEATS-1.
  - After the ack of beat BEATS-1, clear the counter and go to FILL. No idle bus cycle is required between WB and FILL.
- FILL:
  - o_mem_we=0, o_mem_addr = miss_base + k*BEAT_BYTES.
  - On ack, write i_mem_rdata into line[k*BUS_WIDTH +: BUS_WIDTH].
  - After the ack of beat BEATS-1, go to RESP.
- RESP: o_memory_response=1 for exactly one cycle; o_memory_line holds the complete line. Next state CLR.
- CLR: wait until i_miss=0, then go to IDLE. This prevents a second fill from the stale miss level, since the cache clears its miss one cycle after the response.
- o_memory_line holds its value until the next FILL writes beat 0. Partial lines are never presented with response high.
- Address arithmetic wraps modulo 2^ADDRESS_WIDTH. Bases are line-aligned, so a burst never crosses a line boundary.
- Inputs i_miss, i_evict, i_miss_addr and i_evict_* are ignored outside IDLE.
- Minimum miss latency with zero-wait memory, from i_miss high to response:
  - No evict: BEATS+2 cycles.
  - With evict: 2*BEATS+2 cycles.

Decomposition:
- Shared package cache_pkg:
  - State enum (IDLE/WB/FILL/RESP/CLR).
  - LINE_SIZE_BITS, BEATS and BEAT_BYTES derivations.
  - The line-alignment helper, also used by the cache.
- One natural sub-module, line_beat_shifter:
  - Selects the write beat k from the victim line.
  - Deposits the read beat k into the assembly register.
  - Purely indexed slice logic parameterised by BUS_WIDTH/BEATS.

Test Plan:
- Clean miss: i_miss=1, i_miss_addr=0x0000_1234, i_evict=0, zero-wait ack.
  - Expect 16 reads at 0x1200, 0x1204 … 0x123C.
  - Beat k rdata = 0xA000_0000+k lands in bits [32k+:32].
  - Response pulses once at cycle 18; no further requests while i_miss stays high in CLR.
- Dirty eviction: i_evict=1, i_evict_addr=0x0000_5640, victim word k = 0xD000_0000+k, then miss at 0x0000_9900.
  - Expect 16 writes at 0x5640..0x567C with matching data, followed by 16 reads at 0x9900..0x993C.
  - Response at cycle 34.
- Wait states: ack only every 3rd cycle.
  - Addr and wdata are stable while req is high and unacked.
  - Beat count stays exactly 16; line is correct.
- Wrap: i_miss_addr=0xFFFF_FFC8.
  - Base 0xFFFF_FFC0; last beat 0xFFFF_FFFC; no overflow beyond it.
- Reset mid-FILL: assert rst after beat 7 ack.
  - o_mem_req and o_memory_response drop asynchronously; state IDLE.
  - A new miss restarts at beat 0.
- Spurious ack: i_mem_ack pulsed in IDLE and in CLR.
  - No counter change and no data capture.
